// File: rtl/mem_req_queue_if.sv
// Request-queue bus: CPU push side, scheduler pop side and queue status.
// The slave modport is the queue's view; master is the view of whoever drives requests and pops.
interface mem_req_queue_if #(
  parameter int DEPTH  = 16,
  parameter int TIME_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [TIME_W-1:0] in_time;
  logic [1:0]        in_mode;
  logic [35:0]       in_addr;

  logic              out_valid;
  logic              out_ready;
  logic [TIME_W-1:0] out_time;
  logic [1:0]        out_mode;
  logic [17:0]       out_row;
  logic [7:0]        out_col;
  logic [1:0]        out_bank;
  logic [1:0]        out_bg;
  logic [3:0]        out_bank_idx;

  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              err_mode;

  modport slave (
    input  in_valid, in_time, in_mode, in_addr, out_ready,
    output in_ready, out_valid, out_time, out_mode, out_row, out_col,
           out_bank, out_bg, out_bank_idx, count, full, empty, err_mode
  );

  modport master (
    output in_valid, in_time, in_mode, in_addr, out_ready,
    input  in_ready, out_valid, out_time, out_mode, out_row, out_col,
           out_bank, out_bg, out_bank_idx, count, full, empty, err_mode
  );
endinterface

// File: rtl/mem_req_queue.sv
// In-order DRAM request queue with address decode at push and a registered head.
// Optional QUEUE_STATS_EN adds peak_count and total_pushed statistics ports.
module mem_req_queue #(
  parameter int DEPTH  = 16,
  parameter int TIME_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_req_queue_if.slave         bus
`ifdef QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] peak_count,
  output logic [31:0]            total_pushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [1:0]        mode;
    logic [17:0]       row;
    logic [7:0]        col;
    logic [1:0]        bank;
    logic [1:0]        bg;
  } entry_t;

  entry_t        r_mem [DEPTH];
  entry_t        r_head;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic          r_err_mode;

  logic          w_full;
  logic          w_empty;
  logic          w_in_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_head_load;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  entry_t        w_in_entry;
  entry_t        w_head_nxt;
  logic          w_unused_addr;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A mode-3 request still completes its handshake; it is simply never stored.
  assign w_in_fire = bus.in_valid && !w_full;
  assign w_push    = w_in_fire && (bus.in_mode != 2'd3);
  assign w_pop     = r_out_valid && bus.out_ready;

  assign w_in_entry = '{
    t:    bus.in_time,
    mode: bus.in_mode,
    row:  bus.in_addr[35:18],
    col:  bus.in_addr[17:10],
    bank: bus.in_addr[9:8],
    bg:   bus.in_addr[7:6]
  };
  assign w_unused_addr = ^bus.in_addr[5:0];

  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

  // The head register reloads only when the head entry changes; otherwise it holds,
  // which also keeps the data fields at their last value once the queue drains.
  assign w_head_load = (w_count_nxt != '0) && (w_pop || w_empty);
  // When nothing else remains after this cycle's pop, the incoming entry is the new head.
  assign w_head_nxt  = (w_push && ((r_count - CW'(w_pop)) == '0)) ? w_in_entry
                                                                   : r_mem[w_rd_ptr_nxt];

  // NOTE: storage has no reset; the pointers and count define which entries are live,
  // so clearing the array would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_err_mode  <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      if (w_in_fire && (bus.in_mode == 2'd3)) r_err_mode <= 1'b1;
      if (w_head_load) r_head <= w_head_nxt;
    end
  end

  assign bus.in_ready     = !w_full;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_time     = r_head.t;
  assign bus.out_mode     = r_head.mode;
  assign bus.out_row      = r_head.row;
  assign bus.out_col      = r_head.col;
  assign bus.out_bank     = r_head.bank;
  assign bus.out_bg       = r_head.bg;
  assign bus.out_bank_idx = {r_head.bg, r_head.bank};
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.err_mode     = r_err_mode;

`ifdef QUEUE_STATS_EN
  logic [CW-1:0] r_peak_count;
  logic [31:0]   r_total_pushed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak_count   <= '0;
      r_total_pushed <= '0;
    end else begin
      if (w_count_nxt > r_peak_count) r_peak_count <= w_count_nxt;
      if (w_push && (r_total_pushed != '1)) r_total_pushed <= r_total_pushed + 32'd1;
    end
  end

  assign peak_count   = r_peak_count;
  assign total_pushed = r_total_pushed;
`endif

endmodule
